// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and field layout for the RISC-V stage registers.
// Widths default to the EX/MEM boundary; other boundaries override them.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

    localparam int XLEN          = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int EX_MEM_DATA_W = 2 * XLEN + REG_ADDR_W;

    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_ZERO       = 0;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, 2-entry skid,
// flush, bubble-gated control bits and a saturating stall counter.
import riscv_pipe_pkg::*;

module pipe_stage_reg #(
    parameter int DATA_W      = EX_MEM_DATA_W,
    parameter int CTRL_W      = EX_MEM_CTRL_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic main_valid;
    logic accept;
    logic drain;

    assign main_valid = (state_q != EMPTY);
    assign accept     = in_valid && in_ready_q;
    assign drain      = main_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = FULL;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            FULL: begin
                if (accept && drain) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (accept) begin
                    state_d     = SKID;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (drain) begin
                    state_d     = FULL;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_ctrl_d = '0;
                    skid_data_d = '0;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush kills every entry and suppresses any load; payload is held.
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
        end

        in_ready_d = (state_d != SKID);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (main_valid && !out_ready),
        .count(stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic,
// all checked against a queue-based model of the stage.
import riscv_pipe_pkg::*;

module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  in_ctrl = '0;
    logic [68:0] in_data = '0;

    logic        in_ready, out_valid;
    logic [4:0]  out_ctrl;
    logic [68:0] out_data;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [4:0]  out_ctrl2;
    logic [68:0] out_data2;
    logic [1:0]  stall_cnt2;

    int total = 0;
    int bad   = 0;

    logic [73:0] q[$];
    logic [68:0] m_data = '0;
    int          m_cnt  = 0;
    int          m_cnt2 = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_ctrl(out_ctrl2), .out_data(out_data2),
        .stall_cnt(stall_cnt2)
    );

    function automatic logic [68:0] mk(input logic [31:0] alu,
                                       input logic [31:0] rs2,
                                       input logic [4:0]  rd);
        return {alu, rs2, rd};
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] e_ctrl;
        e_ctrl = (q.size() > 0) ? q[0][73:69] : 5'd0;
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("out_ctrl", 128'(out_ctrl), 128'(e_ctrl));
        chk("out_data", 128'(out_data), 128'(m_data));
        chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
        chk("out_valid2", 128'(out_valid2), 128'(q.size() > 0));
        chk("out_data2", 128'(out_data2), 128'(m_data));
        chk("stall_cnt2", 128'(stall_cnt2), 128'(m_cnt2));
    endtask

    // Advance one clock: update the model from current inputs, then check.
    task automatic tick();
        bit acc, drn, stl;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        stl = (q.size() > 0) && !out_ready;
        if (reset) begin
            q.delete();
            m_data = '0;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (stl) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back({in_ctrl, in_data});
                if (q.size() > 0) m_data = q[0][68:0];
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // 1: reset, then pass-through
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        in_ctrl   = 5'b10110;
        in_data   = mk(32'hABCD1234, 32'h11112222, 5'd10);
        out_ready = 1'b1;
        tick();
        chk("pt_memread", 128'(out_ctrl[CTRL_MEM_READ]), 128'(1));
        in_valid = 1'b0;
        tick();

        // 2: back-to-back stream
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 5'(i);
            in_data  = mk(32'(i), 32'h0, 5'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("stream_stall", 128'(stall_cnt), 128'(0));

        // 3: skid fill while downstream stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 5'b00010;
        in_data   = mk(32'h5555AAAA, 32'h1, 5'd1);
        tick();
        in_data   = mk(32'h22223333, 32'h2, 5'd2);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("skid_stall4", 128'(stall_cnt), 128'(4));
        out_ready = 1'b1;
        tick();
        tick();

        // 4: bubble gating with garbage control bits
        in_valid = 1'b0;
        in_ctrl  = 5'b11111;
        tick();
        tick();

        // 5: flush in SKID with a new offer on the input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 5'b01010;
        in_data   = mk(32'hD, 32'hD, 5'd3);
        tick();
        in_data   = mk(32'hE, 32'hE, 5'd4);
        tick();
        flush    = 1'b1;
        in_data  = mk(32'hC, 32'hC, 5'd5);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b1;
        tick();

        // 6: saturate the 2-bit counter, then reset
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = mk(32'hF, 32'hF, 5'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("sat3", 128'(stall_cnt2), 128'(3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sat_rst", 128'(stall_cnt2), 128'(0));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            in_ctrl   = 5'($urandom);
            in_data   = mk($urandom, $urandom, 5'($urandom));
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble-safe control gating. It generalises the fixed EX/MEM stage register into one reusable stage for every boundary: IF/ID, ID/EX, EX/MEM and MEM/WB. Each instance splits its payload into control bits, which are forced to zero on bubbles, and data bits, which are held. It also provides a saturating stall counter for performance monitoring.

Parameters:
DATA_W, 69, width of data payload (EX/MEM: alu_result 32 + rs2_data 32 + rd 5)
CTRL_W, 5, width of control payload (EX/MEM: mem_read, mem_write, mem_to_reg, reg_write, zero)
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered
in_ctrl  in  CTRL_W  upstream control bits
in_data  in  DATA_W  upstream data bits
out_valid  out  1  stage holds a valid entry
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control bits; all zero when out_valid=0
out_data  out  DATA_W  data bits; hold last value when out_valid=0
stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- One clock, synchronous active-high reset on clk.
- Storage: main entry (drives the outputs) and skid entry. in_ready = !skid_valid, registered.
- States:
  - EMPTY: main invalid.
  - FULL: main valid, skid empty.
  - SKID: main and skid both valid.
- Events: accept = in_valid && in_ready; drain = out_valid && out_ready.
- Transitions:
  - EMPTY: accept -> FULL (main <= input).
  - FULL: accept && drain -> FULL (main <= input); accept only -> SKID (skid <= input); drain only -> EMPTY.
  - SKID: drain -> FULL (main <= skid; skid cleared). in_ready=0, so no accept is possible.
- Latency: accepted input appears on out_* the next cycle. Sustained throughput is 1 entry/cycle when out_ready stays high.
- Ordering: strict FIFO. The skid entry is never bypassed.
- Gating: out_ctrl = main_valid ? main_ctrl : 0, combinational. A bubble therefore never asserts a write or read enable downstream.
- out_data changes only on a main load.
- Flush:
  - Next cycle: state EMPTY, in_ready=1.
  - An input offered in the flush cycle is dropped.
  - A drain in the flush cycle still completes; downstream saw a valid handshake.
  - out_data is not cleared.
- Priority: reset > flush > handshake.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, skid contents=0.
- Reset mid-operation discards both entries with no drain.
- stall_cnt:
  - Increments on each cycle with out_valid && !out_ready.
  - Saturates at all-ones; no wrap.
  - Cleared by reset only; unaffected by flush.
- Simultaneous flush and stall: the stall cycle is still counted.
- Widths: CTRL_W >= 1, DATA_W >= 1, STALL_CNT_W >= 2. No arithmetic on the payload.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - Stage-state enum: EMPTY, FULL, SKID.
  - Per-boundary field widths: XLEN=32, REG_ADDR_W=5, EX_MEM_CTRL_W=5, EX_MEM_DATA_W=69.
  - Bit-position constants for control fields: CTRL_MEM_READ=4, CTRL_MEM_WRITE=3, CTRL_MEM_TO_REG=2, CTRL_REG_WRITE=1, CTRL_ZERO=0.
- One natural sub-module: sat_counter, parameter W, with inc and clear inputs. Used for stall_cnt.

Test Plan:
1. Reset then pass-through: reset 2 cycles; in_valid=1, in_ctrl=5'b10110, in_data={32'hABCD1234, 32'h11112222, 5'd10}, out_ready=1 -> next cycle out_valid=1 with identical ctrl/data. After reset, out_ctrl=0, out_data=0, in_ready=1.
2. Back-to-back stream: 4 entries with alu_result 1..4 on consecutive cycles, out_ready=1 -> outputs 1..4 on consecutive cycles, in_ready stays 1, stall_cnt=0.
3. Skid fill: send A=32'h5555AAAA, then B=32'h22223333 while out_ready=0 -> in_ready=0 after B; hold 3 cycles -> stall_cnt=4. Raise out_ready -> A then B delivered in order; in_ready returns to 1 the cycle after A drains.
4. Bubble gating: in_valid=0 while in_ctrl=5'b11111 -> out_valid=0, out_ctrl=5'b00000, out_data unchanged.
5. Flush in SKID state, with in_valid=1 carrying C -> next cycle out_valid=0, in_ready=1, C never appears on the output, stall_cnt retained.
6. Counter saturation with STALL_CNT_W=2: hold out_valid=1 and out_ready=0 for 6 cycles -> stall_cnt=3 and stays 3. Assert reset -> stall_cnt=0 and out_valid=0 the next cycle.
